// File: rtl/mitll_xortn_pkg.sv
// Shared constants and helpers for the mitll_xortn multi-channel clocked XOR model.
// Optional MITLL_XORTN_STATS_EN adds per-channel fire counters of width CNT_W.
package mitll_xortn_pkg;

  localparam int MODE_XOR    = 0;
  localparam int MODE_PARITY = 1;
  localparam int CNT_W       = 16;
  localparam int MAX_NIN     = 16;

  // Callers zero-extend their held vector to MAX_NIN bits.
  function automatic logic [4:0] popcount(input logic [MAX_NIN-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAX_NIN; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/mitll_xortn_if.sv
// Pulse bus of mitll_xortn: toggle-encoded data/evaluation inputs and per-channel outputs.
// fire_cnt exists only when MITLL_XORTN_STATS_EN is defined.
interface mitll_xortn_if
  import mitll_xortn_pkg::*;
#(
  parameter int NIN = 2,
  parameter int NCH = 1
) ();

  logic [NCH*NIN-1:0] din;
  logic               tclk;
  logic [NCH-1:0]     dout;
  logic [NCH-1:0]     ovf;
`ifdef MITLL_XORTN_STATS_EN
  logic [NCH*CNT_W-1:0] fire_cnt;
`endif

  modport master (
    output din,
    output tclk,
    input  dout,
    input  ovf
`ifdef MITLL_XORTN_STATS_EN
    , input fire_cnt
`endif
  );

  modport slave (
    input  din,
    input  tclk,
    output dout,
    output ovf
`ifdef MITLL_XORTN_STATS_EN
    , output fire_cnt
`endif
  );

endinterface

// File: rtl/mitll_xortn_ch.sv
// One channel: stores data pulses until an evaluation pulse, then fires on the MODE rule.
// With MITLL_XORTN_STATS_EN a saturating fire counter is added.
module mitll_xortn_ch
  import mitll_xortn_pkg::*;
#(
  parameter int NIN  = 2,
  parameter int MODE = MODE_XOR
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NIN-1:0] pulse,
  input  logic           eval,
  output logic           dout,
  output logic           ovf
`ifdef MITLL_XORTN_STATS_EN
  , output logic [CNT_W-1:0] fire_cnt
`endif
);

  logic [NIN-1:0]     held_reg;
  logic [MAX_NIN-1:0] held_ext;
  logic [4:0]         k;
  logic               fire;

  always_comb begin
    held_ext = '0;
    held_ext[NIN-1:0] = held_reg;
  end

  assign k    = popcount(held_ext);
  assign fire = eval && ((MODE == MODE_XOR) ? (k == 5'd1) : k[0]);

  // On an evaluation the old window is consumed and any same-cycle pulse opens the next one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_reg <= '0;
      dout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      held_reg <= eval ? pulse : (held_reg | pulse);
      ovf      <= !eval && |(pulse & held_reg);
      if (fire) begin
        dout <= ~dout;
      end
    end
  end

`ifdef MITLL_XORTN_STATS_EN
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (fire && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign fire_cnt = cnt_reg;
`endif

endmodule

// File: rtl/mitll_xortn.sv
// Multi-channel toggle-encoded clocked XOR/parity cell model (top level).
// Define MITLL_XORTN_STATS_EN to expose per-channel fire counters on the bus.
module mitll_xortn
  import mitll_xortn_pkg::*;
#(
  parameter int NIN  = 2,
  parameter int NCH  = 1,
  parameter int MODE = MODE_XOR
) (
  input  logic           clk,
  input  logic           rst_n,
  mitll_xortn_if.slave   bus
);

  logic [NCH*NIN-1:0] din_q;
  logic               tclk_q;
  logic [NCH*NIN-1:0] pulse;
  logic               eval;

  // The delayed copies track the inputs in and out of reset alike, so levels
  // present at reset release never look like pulses.
  always_ff @(posedge clk) begin
    din_q  <= bus.din;
    tclk_q <= bus.tclk;
  end

  assign pulse = bus.din ^ din_q;
  assign eval  = bus.tclk ^ tclk_q;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      mitll_xortn_ch #(
        .NIN  (NIN),
        .MODE (MODE)
      ) u_ch (
        .clk      (clk),
        .rst_n    (rst_n),
        .pulse    (pulse[gi*NIN +: NIN]),
        .eval     (eval),
        .dout     (bus.dout[gi]),
        .ovf      (bus.ovf[gi])
`ifdef MITLL_XORTN_STATS_EN
        , .fire_cnt (bus.fire_cnt[gi*CNT_W +: CNT_W])
`endif
      );
    end
  endgenerate

endmodule

// File: tb/tb_mitll_xortn.sv
// Directed self-checking bench for mitll_xortn: XOR, parity, overflow, same-cycle, reset, multi-channel.
module tb_mitll_xortn;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  mitll_xortn_if #(.NIN(2), .NCH(1)) a_if ();
  mitll_xortn_if #(.NIN(4), .NCH(1)) b_if ();
  mitll_xortn_if #(.NIN(2), .NCH(3)) c_if ();

  mitll_xortn #(.NIN(2), .NCH(1), .MODE(0)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  mitll_xortn #(.NIN(4), .NCH(1), .MODE(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));
  mitll_xortn #(.NIN(2), .NCH(3), .MODE(0)) u_c (.clk(clk), .rst_n(rst_n), .bus(c_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clk edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic obs, input logic exp);
    total_cnt++;
    if (obs !== exp) $display("FAIL %s: got %b expected %b", name, obs, exp);
    else begin pass_cnt++; $display("ok   %s: %b", name, obs); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_if.din = 2'b01; a_if.tclk = 1'b1;
    b_if.din = '0;    b_if.tclk = 1'b0;
    c_if.din = '0;    c_if.tclk = 1'b0;
    step(); step();
    chk1("reset_a_dout", a_if.dout[0], 1'b0);
    chk1("reset_a_ovf",  a_if.ovf[0],  1'b0);
    chk1("reset_b_dout", b_if.dout[0], 1'b0);
    total_cnt++;
    if (c_if.dout !== 3'b000) $display("FAIL reset_c_dout: got %b expected 000", c_if.dout);
    else begin pass_cnt++; $display("ok   reset_c_dout"); end
    rst_n = 1'b1;
    step();
    a_if.tclk ^= 1'b1;
    step();
    chk1("reset_level_no_pulse", a_if.dout[0], 1'b0);
  endtask

  task automatic test_xor();
    a_if.din ^= 2'b01;
    step(); step(); step();
    chk1("xor_wait_no_fire", a_if.dout[0], 1'b0);
    a_if.tclk ^= 1'b1;
    step();
    chk1("xor_k1_fire", a_if.dout[0], 1'b1);
    a_if.din ^= 2'b11;
    step();
    a_if.tclk ^= 1'b1;
    step();
    chk1("xor_k2_no_fire", a_if.dout[0], 1'b1);
    a_if.din ^= 2'b10;
    step();
    a_if.tclk ^= 1'b1;
    step();
    chk1("xor_held_cleared", a_if.dout[0], 1'b0);
  endtask

  task automatic test_parity();
    b_if.din ^= 4'b0111;
    step();
    b_if.tclk ^= 1'b1;
    step();
    chk1("parity_k3_fire", b_if.dout[0], 1'b1);
    b_if.din ^= 4'b0011;
    step();
    b_if.tclk ^= 1'b1;
    step();
    chk1("parity_k2_no_fire", b_if.dout[0], 1'b1);
    b_if.tclk ^= 1'b1;
    step();
    chk1("parity_k0_no_fire", b_if.dout[0], 1'b1);
    b_if.din ^= 4'b1000;
    step();
    b_if.tclk ^= 1'b1;
    step();
    chk1("parity_k1_fire", b_if.dout[0], 1'b0);
  endtask

  task automatic test_overflow();
    a_if.din ^= 2'b01;
    step();
    chk1("ovf_first_pulse", a_if.ovf[0], 1'b0);
    step();
    a_if.din ^= 2'b01;
    step();
    chk1("ovf_second_pulse", a_if.ovf[0], 1'b1);
    step();
    chk1("ovf_one_cycle", a_if.ovf[0], 1'b0);
    a_if.tclk ^= 1'b1;
    step();
    chk1("ovf_then_fire", a_if.dout[0], 1'b1);
  endtask

  task automatic test_back_to_back();
    a_if.din ^= 2'b01;
    step();
    a_if.din ^= 2'b10;
    a_if.tclk ^= 1'b1;
    step();
    chk1("simul_old_k_fire", a_if.dout[0], 1'b0);
    chk1("simul_no_ovf", a_if.ovf[0], 1'b0);
    a_if.tclk ^= 1'b1;
    step();
    chk1("simul_carry_fire", a_if.dout[0], 1'b1);
    a_if.tclk ^= 1'b1;
    step();
    chk1("b2b_empty_no_fire", a_if.dout[0], 1'b1);
  endtask

  task automatic test_mid_reset();
    a_if.din ^= 2'b01;
    step();
    rst_n = 1'b0;
    step();
    chk1("midrst_dout", a_if.dout[0], 1'b0);
    chk1("midrst_ovf", a_if.ovf[0], 1'b0);
    rst_n = 1'b1;
    a_if.tclk ^= 1'b1;
    step();
    chk1("midrst_no_fire", a_if.dout[0], 1'b0);
  endtask

  task automatic test_channels();
    c_if.din ^= 6'b000100;
    step();
    c_if.tclk ^= 1'b1;
    step();
    total_cnt++;
    if (c_if.dout !== 3'b010) $display("FAIL ch1_fire: got %b expected 010", c_if.dout);
    else begin pass_cnt++; $display("ok   ch1_fire"); end
    c_if.din ^= 6'b000100;
    step();
    c_if.tclk ^= 1'b1;
    step();
    total_cnt++;
    if (c_if.dout !== 3'b000) $display("FAIL ch1_fire2: got %b expected 000", c_if.dout);
    else begin pass_cnt++; $display("ok   ch1_fire2"); end
    // Channel 0 gets k=2 (no fire) while channel 2 gets k=1 (fire).
    c_if.din ^= 6'b010011;
    step();
    c_if.tclk ^= 1'b1;
    step();
    total_cnt++;
    if (c_if.dout !== 3'b100) $display("FAIL ch_indep: got %b expected 100", c_if.dout);
    else begin pass_cnt++; $display("ok   ch_indep"); end
`ifdef MITLL_XORTN_STATS_EN
    total_cnt++;
    if (c_if.fire_cnt !== {16'd1, 16'd2, 16'd0})
      $display("FAIL fire_cnt: got %h expected 000100020000", c_if.fire_cnt);
    else begin pass_cnt++; $display("ok   fire_cnt"); end
    c_if.din ^= 6'b000001;
    step();
    for (int n = 0; n < 65537; n++) begin
      c_if.din ^= 6'b000001;
      c_if.tclk ^= 1'b1;
      step();
    end
    total_cnt++;
    if (c_if.fire_cnt[15:0] !== 16'hFFFF)
      $display("FAIL fire_cnt_sat: got %h expected ffff", c_if.fire_cnt[15:0]);
    else begin pass_cnt++; $display("ok   fire_cnt_sat"); end
`endif
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_xor();
    test_parity();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    test_channels();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
